// File: rtl/conv_pkg.sv
// Shared types and helpers for the layer-1 post-processing path.
// Contents:
//   CONV_OUT_W / ACT_W  - accumulator and activation widths
//   act_t               - signed 16-bit activation
//   pool_state_e        - pooling FSM row-parity state
//   sat_act()           - clamp a 32-bit signed value into act_t
//   act_max()           - signed maximum of two activations
package conv_pkg;

    localparam int CONV_OUT_W = 32;
    localparam int ACT_W      = 16;

    typedef logic signed [ACT_W-1:0] act_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pool_state_e;

    function automatic act_t sat_act(input logic signed [CONV_OUT_W-1:0] v);
        act_t res;
        if (v > 32'sd32767) begin
            res = 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            res = 16'sh8000;
        end else begin
            res = act_t'(v[ACT_W-1:0]);
        end
        return res;
    endfunction

    function automatic act_t act_max(input act_t a, input act_t b);
        act_t res;
        if (a > b) begin
            res = a;
        end else begin
            res = b;
        end
        return res;
    endfunction

endpackage

// File: rtl/relu_maxpool_stage_relu_requant.sv
// relu_requant: first pipeline stage of relu_maxpool_stage.
// ReLU on the raw accumulator, optional round-half-up, arithmetic right shift
// by SHIFT, saturation to act_t, all registered in one cycle.
// Build option: REQUANT_ROUND_EN adds 1<<(SHIFT-1) (saturating at 32 bits)
// before the shift; latency is the same either way.
// Ports:
//   h_clk      in   clock, posedge
//   reset      in   synchronous active-high reset
//   in_data    in   32-bit signed accumulator
//   in_valid   in   accumulator valid
//   act_data   out  requantised activation (registered)
//   act_valid  out  activation valid (registered)
module relu_requant
    import conv_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic                         h_clk,
    input  logic                         reset,
    input  logic signed [CONV_OUT_W-1:0] in_data,
    input  logic                         in_valid,
    output act_t                         act_data,
    output logic                         act_valid
);

`ifdef REQUANT_ROUND_EN
    localparam logic [CONV_OUT_W:0] ROUND_C = (SHIFT > 0) ? (33'd1 << (SHIFT - 1)) : 33'd0;
    logic [CONV_OUT_W:0] sum_s;
`endif

    logic signed [CONV_OUT_W-1:0] relu_s;
    logic signed [CONV_OUT_W-1:0] rounded_s;
    logic signed [CONV_OUT_W-1:0] shifted_s;
    act_t                         act_s;
    act_t                         act_data_r;
    logic                         act_valid_r;

    // ReLU, optional rounding, shift and saturation of the incoming sample.
    always_comb begin
        relu_s    = 32'sd0;
        rounded_s = 32'sd0;
        shifted_s = 32'sd0;
        act_s     = 16'sd0;
        if (in_data[CONV_OUT_W-1]) begin
            relu_s = 32'sd0;
        end else begin
            relu_s = in_data;
        end
`ifdef REQUANT_ROUND_EN
        // relu_s is non-negative, so any carry into bit 31 or above is overflow.
        sum_s = {1'b0, relu_s} + ROUND_C;
        if (sum_s[CONV_OUT_W:CONV_OUT_W-1] != 2'b00) begin
            rounded_s = 32'sh7FFF_FFFF;
        end else begin
            rounded_s = $signed(sum_s[CONV_OUT_W-1:0]);
        end
`else
        rounded_s = relu_s;
`endif
        shifted_s = rounded_s >>> SHIFT;
        act_s     = sat_act(shifted_s);
    end

    // Stage-1 pipeline register; reset drops any pixel presented with it.
    always_ff @(posedge h_clk) begin
        if (reset) begin
            act_valid_r <= 1'b0;
            act_data_r  <= 16'sd0;
        end else begin
            act_valid_r <= in_valid;
            if (in_valid) begin
                act_data_r <= act_s;
            end else begin
                act_data_r <= act_data_r;
            end
        end
    end

    assign act_data  = act_data_r;
    assign act_valid = act_valid_r;

endmodule

// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage: ReLU + requantise + 2x2/stride-2 max-pool on the
// row-major conv layer-1 accumulator stream.
// Build option: REQUANT_ROUND_EN (round-half-up before the requant shift).
// Ports:
//   h_clk       in   clock, posedge
//   reset       in   synchronous active-high reset
//   in_data     in   32-bit signed conv result
//   in_valid    in   in_data valid (gaps allowed, no backpressure)
//   in_finish   in   1-cycle frame-complete pulse from the conv layer
//   out_data    out  16-bit signed pooled activation
//   out_valid   out  1-cycle pulse per pooled pixel
//   out_finish  out  pulse with the last pooled pixel of a frame
//   invalid     out  pulse when in_finish arrives at an illegal point
// Latency: out_valid follows the window's bottom-right in_valid by 2 cycles.
module relu_maxpool_stage
    import conv_pkg::*;
#(
    parameter int FMAP_W = 8,
    parameter int FMAP_H = 8,
    parameter int SHIFT  = 8
) (
    input  logic        h_clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_finish,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_finish,
    output logic        invalid
);

    localparam int COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int LB_D  = FMAP_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    generate
        if (((FMAP_W % 2) != 0) || ((FMAP_H % 2) != 0) || (FMAP_W < 2) || (FMAP_H < 2)) begin : g_bad_dims
            $error("relu_maxpool_stage: FMAP_W and FMAP_H must be even and >= 2");
        end
    endgenerate

    act_t              s1_data_s;
    logic              s1_valid_s;
    logic              fin_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    pool_state_e       state_r;
    act_t              hmax_r;
    act_t              lb_r [LB_D];
    logic [15:0]       out_data_r;
    logic              out_valid_r;
    logic              out_finish_r;
    logic              invalid_r;

    logic              col_last_s;
    logic              row_last_s;
    logic              count_zero_s;
    logic              frame_last_s;
    logic              abort_s;
    logic [LB_AW-1:0]  lb_idx_s;
    act_t              pair_max_s;
    act_t              win_max_s;
    logic              lb_we_s;

    relu_requant #(
        .SHIFT (SHIFT)
    ) u_relu_requant (
        .h_clk     (h_clk),
        .reset     (reset),
        .in_data   ($signed(in_data)),
        .in_valid  (in_valid),
        .act_data  (s1_data_s),
        .act_valid (s1_valid_s)
    );

    // Delay in_finish by one cycle so it lines up with the stage-1 pixel it accompanied.
    always_ff @(posedge h_clk) begin
        if (reset) begin
            fin_r <= 1'b0;
        end else begin
            fin_r <= in_finish;
        end
    end

    // Window position, pooling maxima and finish legality for the current stage-1 pixel.
    always_comb begin
        col_last_s   = (col_r == COL_W'(FMAP_W - 1));
        row_last_s   = (row_r == ROW_W'(FMAP_H - 1));
        count_zero_s = (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
        frame_last_s = s1_valid_s && col_last_s && row_last_s;
        // A finish is only acceptable on the final pixel or between frames.
        abort_s      = fin_r && !frame_last_s && !count_zero_s;
        lb_idx_s     = LB_AW'(col_r >> 1);
        pair_max_s   = act_max(hmax_r, s1_data_s);
        win_max_s    = act_max(lb_r[lb_idx_s], pair_max_s);
        lb_we_s      = !reset && !abort_s && s1_valid_s && col_r[0] && (state_r == EVEN);
    end

    // Line buffer of even-row pair maxima; every entry is written before it is read, so no reset.
    always_ff @(posedge h_clk) begin
        if (lb_we_s) begin
            lb_r[lb_idx_s] <= pair_max_s;
        end
    end

    // Pooling FSM: counters, horizontal pair register and registered outputs.
    always_ff @(posedge h_clk) begin
        if (reset) begin
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            state_r      <= EVEN;
            hmax_r       <= 16'sd0;
            out_data_r   <= 16'd0;
            out_valid_r  <= 1'b0;
            out_finish_r <= 1'b0;
            invalid_r    <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            out_finish_r <= 1'b0;
            invalid_r    <= abort_s;
            if (abort_s) begin
                col_r   <= {COL_W{1'b0}};
                row_r   <= {ROW_W{1'b0}};
                state_r <= EVEN;
            end else if (s1_valid_s) begin
                if (!col_r[0]) begin
                    hmax_r <= s1_data_s;
                end else begin
                    case (state_r)
                        EVEN: begin
                            hmax_r <= hmax_r;
                        end
                        ODD: begin
                            out_data_r   <= win_max_s;
                            out_valid_r  <= 1'b1;
                            out_finish_r <= row_last_s && col_last_s;
                        end
                        default: begin
                            state_r <= EVEN;
                        end
                    endcase
                end
                if (col_last_s) begin
                    col_r   <= {COL_W{1'b0}};
                    state_r <= (state_r == EVEN) ? ODD : EVEN;
                    if (row_last_s) begin
                        row_r <= {ROW_W{1'b0}};
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_finish = out_finish_r;
    assign invalid    = invalid_r;

endmodule
